// File: rtl/and_gate_exerciser_if.sv
// Bus between the AND-gate exerciser and its bench/self-test wrapper.
// AND_EXER_FIRST_FAIL_EN adds the first-failure capture signals.
interface and_gate_exerciser_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic             y_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
`ifdef AND_EXER_FIRST_FAIL_EN
  logic             first_fail_valid;
  logic [1:0]       first_fail_vec;
  logic             first_fail_y;

  modport master (output start, y_in,
                  input  a_out, b_out, busy, done, pass, err_count,
                         first_fail_valid, first_fail_vec, first_fail_y);
  modport slave  (input  start, y_in,
                  output a_out, b_out, busy, done, pass, err_count,
                         first_fail_valid, first_fail_vec, first_fail_y);
`else
  modport master (output start, y_in,
                  input  a_out, b_out, busy, done, pass, err_count);
  modport slave  (input  start, y_in,
                  output a_out, b_out, busy, done, pass, err_count);
`endif
endinterface

// File: rtl/and_gate_exerciser.sv
// Sweeps all four {a,b} vectors into a 2-input AND gate, checks y per vector.
// Optional first-failure capture under AND_EXER_FIRST_FAIL_EN.
module and_gate_exerciser #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  and_gate_exerciser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] LAST_PASS  = 8'(PASSES - 1);
  localparam logic [7:0] SET_LAST   = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       vec;
  logic [7:0]       set_cnt;
  logic [7:0]       pass_cnt;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic             mism;
  logic [ERR_W-1:0] err_nxt;

  // Compare against the registered drive, not vec, so the check sees what the gate saw
  assign mism    = bus.y_in != (a_q & b_q);
  assign err_nxt = (mism && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_ONE : err_q;

`ifdef AND_EXER_FIRST_FAIL_EN
  logic       ff_valid;
  logic [1:0] ff_vec;
  logic       ff_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_vec   <= 2'b00;
      ff_y     <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      ff_valid <= 1'b0;
      ff_vec   <= 2'b00;
      ff_y     <= 1'b0;
    end else if (state == SAMPLE && mism && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_vec   <= {a_q, b_q};
      ff_y     <= bus.y_in;
    end
  end

  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_vec   = ff_vec;
  assign bus.first_fail_y     = ff_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= 2'd0;
      set_cnt  <= 8'd0;
      pass_cnt <= 8'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state    <= DRIVE;
          vec      <= 2'd0;
          pass_cnt <= 8'd0;
          err_q    <= '0;
          pass_q   <= 1'b0;
          busy_q   <= 1'b1;
        end
        DRIVE: begin
          {a_q, b_q} <= vec;
          set_cnt    <= 8'd0;
          state      <= (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
        end
        SETTLE: begin
          if (set_cnt == SET_LAST) state <= SAMPLE;
          else                     set_cnt <= set_cnt + 8'd1;
        end
        SAMPLE: begin
          err_q <= err_nxt;
          if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            state <= DRIVE;
          end else if (pass_cnt < LAST_PASS) begin
            vec      <= 2'd0;
            pass_cnt <= pass_cnt + 8'd1;
            state    <= DRIVE;
          end else begin
            // Verdict includes a mismatch found in this final sample
            state  <= DONE;
            done_q <= 1'b1;
            pass_q <= (err_nxt == '0);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
endmodule
